// File: rtl/mawg_pkg.sv
// Shared ADSR stage encodings, also decoded by the control/status register block.
package mawg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsr_state_e;

endpackage

// File: rtl/envelope_adsr_scale.sv
// env_scale: signed sample times unsigned envelope level, scaled back down by 2^E.
module env_scale #(
  parameter int M = 16,
  parameter int E = 16
) (
  input  logic [M-1:0] sample_i,
  input  logic [E-1:0] level_i,
  output logic [M-1:0] scaled_o
);

  // The product of an M-bit signed value and a zero-extended E-bit level fits in M+E signed bits.
  logic signed [M+E-1:0] prod;

  assign prod     = $signed(sample_i) * $signed({1'b0, level_i});
  assign scaled_o = M'(prod >>> E);

endmodule

// File: rtl/envelope_adsr.sv
// ADSR amplitude envelope applied to the oscillator sample; output registered.
// Optional RETRIGGER_EN adds a trig input that hard-restarts ATTACK from level 0.
module envelope_adsr
  import mawg_pkg::*;
#(
  parameter int M = 16,
  parameter int E = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         gate,
`ifdef RETRIGGER_EN
  input  logic         trig,
`endif
  input  logic [E-1:0] attack_rate,
  input  logic [E-1:0] decay_rate,
  input  logic [E-1:0] sustain_level,
  input  logic [E-1:0] release_rate,
  input  logic [M-1:0] sample,
  output logic [M-1:0] value,
  output logic [2:0]   stage,
  output logic         active
);

  localparam logic [E-1:0] LevelMax = {E{1'b1}};

  adsr_state_e       state_q, state_d;
  logic [E-1:0]      level_q, level_d;
  logic [M-1:0]      value_q;
  logic [M-1:0]      scaled;
  logic [E:0]        attackSum;
  logic signed [E:0] decayDiff;

  env_scale #(.M(M), .E(E)) u_scale (
    .sample_i (sample),
    .level_i  (level_q),
    .scaled_o (scaled)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      level_q <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      value_q <= scaled;
    end
  end

  // Gate checks come before tick so a note-off is never lost to a level step.
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    attackSum = {1'b0, level_q} + {1'b0, attack_rate};
    decayDiff = $signed({1'b0, level_q}) - $signed({1'b0, decay_rate});
    case (state_q)
      IDLE: begin
        level_d = '0;
        if (gate) state_d = ATTACK;
      end
      ATTACK: begin
        if (!gate) begin
          state_d = RELEASE;
        end else if (tick) begin
          if (attackSum >= {1'b0, LevelMax}) begin
            level_d = LevelMax;
            state_d = DECAY;
          end else begin
            level_d = attackSum[E-1:0];
          end
        end
      end
      DECAY: begin
        if (!gate) begin
          state_d = RELEASE;
        end else if (tick) begin
          if (decayDiff <= $signed({1'b0, sustain_level})) begin
            level_d = sustain_level;
            state_d = SUSTAIN;
          end else begin
            level_d = decayDiff[E-1:0];
          end
        end
      end
      SUSTAIN: begin
        if (!gate) state_d = RELEASE;
        else       level_d = sustain_level;
      end
      RELEASE: begin
        if (gate) begin
          state_d = ATTACK;
        end else if (tick) begin
          if (level_q <= release_rate) begin
            level_d = '0;
            state_d = IDLE;
          end else begin
            level_d = level_q - release_rate;
          end
        end
      end
      default: begin
        state_d = IDLE;
        level_d = '0;
      end
    endcase
`ifdef RETRIGGER_EN
    if (gate && trig) begin
      state_d = ATTACK;
      level_d = '0;
    end
`endif
  end

  always_comb begin
    value  = value_q;
    stage  = state_q;
    active = (state_q != IDLE);
  end

endmodule

// File: tb/tb_envelope_adsr.sv
// Randomized scoreboard bench for envelope_adsr against an integer ADSR reference model.
// Define RETRIGGER_EN to also exercise the trig input.
module tb_envelope_adsr;

   localparam int M = 16;
   localparam int E = 16;
   localparam int LevelMax = 65535;

   typedef struct packed {
      logic [15:0] value;
      logic [2:0]  stage;
      logic        active;
   } expT;

   logic        clk = 1'b0;
   logic        rstN;
   logic        tickIn;
   logic        gateIn;
`ifdef RETRIGGER_EN
   logic        trigIn;
`endif
   logic [15:0] attackRate;
   logic [15:0] decayRate;
   logic [15:0] sustainLevel;
   logic [15:0] releaseRate;
   logic [15:0] sampleIn;
   logic [15:0] value;
   logic [2:0]  stage;
   logic        active;

   expT expQ[$];
   expT monExp;
   int  checks = 0;
   int  passes = 0;
   int  mState = 0;
   int  mLevel = 0;
   bit  randSample = 1'b0;

   // 10 ns clock.
   always #5 clk = ~clk;

   envelope_adsr #(.M(M), .E(E)) dut (
      .clk           (clk),
      .rst           (rstN),
      .tick          (tickIn),
      .gate          (gateIn),
`ifdef RETRIGGER_EN
      .trig          (trigIn),
`endif
      .attack_rate   (attackRate),
      .decay_rate    (decayRate),
      .sustain_level (sustainLevel),
      .release_rate  (releaseRate),
      .sample        (sampleIn),
      .value         (value),
      .stage         (stage),
      .active        (active)
   );

   // Drive the current inputs for a number of cycles; for each edge the reference model
   // predicts the post-edge outputs and queues them for the monitor.
   task automatic applyStimulus(input int cycles);
      int     a, d, s, r, nState, nLevel;
      longint prod;
      logic [15:0] expVal;
      for (int c = 0; c < cycles; c++) begin
         if (randSample) sampleIn = 16'($urandom);
         a = attackRate;
         d = decayRate;
         s = sustainLevel;
         r = releaseRate;
         prod = longint'($signed(sampleIn)) * longint'(mLevel);
         expVal = 16'(prod >>> 16);
         nState = mState;
         nLevel = mLevel;
         if (!rstN) begin
            nState = 0;
            nLevel = 0;
            expVal = 16'h0000;
         end else begin
            case (mState)
               0: begin
                  nLevel = 0;
                  if (gateIn) nState = 1;
               end
               1: if (!gateIn) nState = 4;
                  else if (tickIn) begin
                     if (mLevel + a >= LevelMax) begin nLevel = LevelMax; nState = 2; end
                     else nLevel = mLevel + a;
                  end
               2: if (!gateIn) nState = 4;
                  else if (tickIn) begin
                     if (mLevel - d <= s) begin nLevel = s; nState = 3; end
                     else nLevel = mLevel - d;
                  end
               3: if (!gateIn) nState = 4;
                  else nLevel = s;
               4: if (gateIn) nState = 1;
                  else if (tickIn) begin
                     if (mLevel <= r) begin nLevel = 0; nState = 0; end
                     else nLevel = mLevel - r;
                  end
               default: begin nState = 0; nLevel = 0; end
            endcase
`ifdef RETRIGGER_EN
            if (gateIn && trigIn) begin
               nState = 1;
               nLevel = 0;
            end
`endif
         end
         mState = nState;
         mLevel = nLevel;
         expQ.push_back(expT'{expVal, 3'(nState), (nState != 0)});
         @(posedge clk);
         #1;
      end
   endtask

   // Compare one queued expectation against what the DUT shows after the edge.
   task automatic checkOutput(input expT e);
      checks++;
      if (value === e.value) passes++;
      else $display("[TB] FAIL value: got %h expected %h at %0t", value, e.value, $time);
      checks++;
      if (stage === e.stage) passes++;
      else $display("[TB] FAIL stage: got %0d expected %0d at %0t", stage, e.stage, $time);
      checks++;
      if (active === e.active) passes++;
      else $display("[TB] FAIL active: got %b expected %b at %0t", active, e.active, $time);
   endtask

   // Monitor: every falling edge, the oldest prediction belongs to the preceding rising edge.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         monExp = expQ.pop_front();
         checkOutput(monExp);
      end
   end

   initial begin
      rstN = 1'b0; tickIn = 1'b1; gateIn = 1'b0;
`ifdef RETRIGGER_EN
      trigIn = 1'b0;
`endif
      attackRate = 16'h4000; decayRate = 16'h3000;
      sustainLevel = 16'h8000; releaseRate = 16'h3000; sampleIn = 16'h4000;
      applyStimulus(2);
      rstN = 1'b1; applyStimulus(1);

      // Reset held two cycles in the middle of an attack.
      gateIn = 1'b1; applyStimulus(3);
      rstN = 1'b0; applyStimulus(2);
      rstN = 1'b1; applyStimulus(1);

      // Attack to full scale, decay with tick pauses, settle in sustain.
      applyStimulus(5);
      tickIn = 1'b0; applyStimulus(3);
      tickIn = 1'b1; applyStimulus(4);

      // Scaling corners: full-scale level with most-negative sample, then half level.
      sampleIn = 16'h8000; sustainLevel = 16'hFFFF; applyStimulus(2);
      sampleIn = 16'h4000; sustainLevel = 16'h8000; applyStimulus(2);

      // Release to idle, then note-off mid-attack and re-gate during release.
      gateIn = 1'b0; applyStimulus(4);
      gateIn = 1'b1; applyStimulus(3);
      gateIn = 1'b0; applyStimulus(2);
      gateIn = 1'b1; applyStimulus(3);

      // Zero rate holds the level in the current stage.
      attackRate = 16'h0000; applyStimulus(6);
      attackRate = 16'h4000; applyStimulus(6);

`ifdef RETRIGGER_EN
      // Hard restart from sustain, and trig ignored while the gate is low.
      trigIn = 1'b1; applyStimulus(1);
      trigIn = 1'b0; applyStimulus(8);
      gateIn = 1'b0; trigIn = 1'b1; applyStimulus(2);
      trigIn = 1'b0; gateIn = 1'b1; applyStimulus(2);
`endif

      // Randomized segments with occasional zero/extreme rates and resets.
      randSample = 1'b1;
      for (int i = 0; i < 300; i++) begin
         rstN   = ($urandom_range(0, 19) != 0);
         gateIn = ($urandom_range(0, 3) != 0);
         tickIn = ($urandom_range(0, 3) != 0);
`ifdef RETRIGGER_EN
         trigIn = ($urandom_range(0, 9) == 0);
`endif
         attackRate   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'h6000));
         decayRate    = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'h6000));
         releaseRate  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'h6000));
         sustainLevel = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
         applyStimulus($urandom_range(1, 12));
      end
      randSample = 1'b0;

      // Drain outstanding predictions within a bounded number of cycles.
      for (int w = 0; w < 10 && expQ.size() > 0; w++) @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
         checks++;
         $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
